register_bank: RTL

- Parametrised successor to the single 8-bit load/enable register: a bank of DEPTH registers, each WIDTH bits wide.
- One write port executes an in-place register operation: load, clear, shift, rotate, increment or decrement.
- Two registered read ports supply ALU operands.
- Sits between the ALU datapath and the control sequencer as the working-register store.

---
 rtl/register_bank_pkg.sv | 15 +
 rtl/register_bank_op.sv | 52 +++++
 rtl/register_bank.sv | 86 ++++++++
 3 files changed

// File: rtl/register_bank_pkg.sv
// Shared constants for the register bank: write-port operation encodings.
package register_bank_pkg;

   localparam int MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_LOAD  = 3'b000;
   localparam logic [MODE_W-1:0] MODE_CLEAR = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL   = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR   = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL   = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROR   = 3'b101;
   localparam logic [MODE_W-1:0] MODE_INC   = 3'b110;
   localparam logic [MODE_W-1:0] MODE_DEC   = 3'b111;

endpackage

// File: rtl/register_bank_op.sv
// Combinational in-place register operation: next value and carry/shift-out
// for load, clear, shift, rotate, increment and decrement.
module register_bank_op
   import register_bank_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0]  cur,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  nxt,
   output logic              carry
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      nxt   = cur;
      carry = 1'b0;
      case (mode)
         MODE_LOAD:  nxt = wr_data;
         MODE_CLEAR: nxt = '0;
         MODE_SHL: begin
            nxt   = {cur[WIDTH-2:0], 1'b0};
            carry = cur[WIDTH-1];
         end
         MODE_SHR: begin
            nxt   = {1'b0, cur[WIDTH-1:1]};
            carry = cur[0];
         end
         MODE_ROL: begin
            nxt   = {cur[WIDTH-2:0], cur[WIDTH-1]};
            carry = cur[WIDTH-1];
         end
         MODE_ROR: begin
            nxt   = {cur[0], cur[WIDTH-1:1]};
            carry = cur[0];
         end
         MODE_INC: begin
            nxt   = cur + ONE;
            carry = &cur;
         end
         MODE_DEC: begin
            nxt   = cur - ONE;
            carry = ~|cur;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/register_bank.sv
// Working-register bank: one operate-in-place write port, two registered read ports.
// Define REGISTER_BANK_BYPASS_EN to forward a same-cycle write result to the readers.
module register_bank
   import register_bank_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [MODE_W-1:0] wr_mode,
   input  logic [WIDTH-1:0]  wr_data,
   output logic              carry,
   input  logic              rd_en_a,
   input  logic [AW-1:0]     rd_addr_a,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic              rd_valid_a,
   input  logic              rd_en_b,
   input  logic [AW-1:0]     rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_b,
   output logic              rd_valid_b
);

   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] regs [DEPTH];
   logic [WIDTH-1:0] cur, pre_a, pre_b, fwd_a, fwd_b, op_nxt;
   logic             op_carry, wr_ok;

   assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_W);

   // Decoded lookups; addresses beyond DEPTH match nothing and read as zero.
   always_comb begin
      cur   = '0;
      pre_a = '0;
      pre_b = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_addr   == AW'(i)) cur   = regs[i];
         if (rd_addr_a == AW'(i)) pre_a = regs[i];
         if (rd_addr_b == AW'(i)) pre_b = regs[i];
      end
   end

   register_bank_op #(.WIDTH(WIDTH)) u_op (
      .cur     (cur),
      .mode    (wr_mode),
      .wr_data (wr_data),
      .nxt     (op_nxt),
      .carry   (op_carry)
   );

`ifdef REGISTER_BANK_BYPASS_EN
   assign fwd_a = (wr_ok && rd_addr_a == wr_addr) ? op_nxt : pre_a;
   assign fwd_b = (wr_ok && rd_addr_b == wr_addr) ? op_nxt : pre_b;
`else
   assign fwd_a = pre_a;
   assign fwd_b = pre_b;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the whole array is reset because the bank must read as zero after reset;
         // this keeps it in flops rather than RAM, which is fine at this depth.
         for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
         carry      <= 1'b0;
         rd_data_a  <= '0;
         rd_valid_a <= 1'b0;
         rd_data_b  <= '0;
         rd_valid_b <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so reads sample the pre-edge contents of regs.
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && wr_addr == AW'(i)) regs[i] <= op_nxt;
         end
         if (wr_ok) carry <= op_carry;
         rd_valid_a <= rd_en_a;
         rd_valid_b <= rd_en_b;
         if (rd_en_a) rd_data_a <= fwd_a;
         if (rd_en_b) rd_data_b <= fwd_b;
      end
   end

endmodule
